// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
//  Package     : pipe_ctrl_pkg
//  Description : Shared types and helpers for the pipeline hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } ctrl_out_t;

    // Normal-flow controls: a taken branch kills the Decode instruction, so it
    // takes precedence over any load-use stall on that same instruction.
    function automatic ctrl_out_t run_outputs(input logic lu, input logic pc_src);
        ctrl_out_t w_o;
        w_o = '0;
        if (pc_src) begin
            w_o.flush_d = 1'b1;
            w_o.flush_e = 1'b1;
        end else if (lu) begin
            w_o.stall_f = 1'b1;
            w_o.stall_d = 1'b1;
            w_o.flush_e = 1'b1;
        end
        return w_o;
    endfunction

    // Whole pipe frozen with a bubble pushed into Writeback.
    function automatic ctrl_out_t freeze_outputs();
        ctrl_out_t w_o;
        w_o         = '0;
        w_o.stall_f = 1'b1;
        w_o.stall_d = 1'b1;
        w_o.stall_e = 1'b1;
        w_o.stall_m = 1'b1;
        w_o.flush_w = 1'b1;
        return w_o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use hazard comparator (Execute vs Decode).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_rs1_d,
    input  logic [REG_W-1:0] i_rs2_d,
    input  logic [REG_W-1:0] i_rd_e,
    input  logic             i_load_e,
    output logic             o_lu
);

    logic w_rd_nz;
    logic w_match;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign w_rd_nz = |i_rd_e;
    assign w_match = (i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d);
    assign o_lu    = i_load_e & w_rd_nz & w_match;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush sequencer for the 5-stage pipeline registers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] i_rs1_d,
    input  logic [REG_W-1:0] i_rs2_d,
    input  logic [REG_W-1:0] i_rd_e,
    input  logic             i_load_e,
    input  logic             i_pc_src_e,
    input  logic             i_mem_req_m,
    input  logic             i_mem_ready_m,
    input  logic             i_halt_req,
    output logic             o_stall_f,
    output logic             o_stall_d,
    output logic             o_stall_e,
    output logic             o_stall_m,
    output logic             o_flush_d,
    output logic             o_flush_e,
    output logic             o_flush_w,
    output logic             o_halted,
    output logic             o_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int                c_WAIT_W    = $clog2(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

    ctrl_state_t         r_state;
    ctrl_state_t         w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic                r_err;
    logic                w_err_set;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                w_lu;
    logic                w_ms;
    logic                w_mem_done;
    ctrl_out_t           w_ctrl;

    hazard_detect u_hazard_detect (
        .i_rs1_d  (i_rs1_d),
        .i_rs2_d  (i_rs2_d),
        .i_rd_e   (i_rd_e),
        .i_load_e (i_load_e),
        .o_lu     (w_lu)
    );

    // A ready strobe only counts while a request is actually outstanding.
    assign w_ms       = i_mem_req_m & ~i_mem_ready_m;
    assign w_mem_done = i_mem_req_m &  i_mem_ready_m;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_err_set   = 1'b0;
        case (r_state)
            RUN: begin
                if (w_ms) begin
                    w_state_nxt = MWAIT;
                    w_wait_nxt  = c_WAIT_ONE;
                end else if (i_halt_req) begin
                    w_state_nxt = HALT;
                end
            end
            MWAIT: begin
                if (w_mem_done) begin
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt = HALT;
                    w_wait_nxt  = '0;
                    w_err_set   = 1'b1;
                end else begin
                    w_wait_nxt  = r_wait_cnt + 1'b1;
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // The completing MWAIT cycle already behaves like RUN so the pipe restarts
    // without a dead cycle.
    always_comb begin
        w_ctrl = '0;
        if (!reset) begin
            case (r_state)
                RUN:     w_ctrl = w_ms ? freeze_outputs() : run_outputs(w_lu, i_pc_src_e);
                MWAIT:   w_ctrl = w_mem_done ? run_outputs(w_lu, i_pc_src_e) : freeze_outputs();
                HALT:    w_ctrl = freeze_outputs();
                default: w_ctrl = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_ctrl.stall_f && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_stall_f   = w_ctrl.stall_f;
    assign o_stall_d   = w_ctrl.stall_d;
    assign o_stall_e   = w_ctrl.stall_e;
    assign o_stall_m   = w_ctrl.stall_m;
    assign o_flush_d   = w_ctrl.flush_d;
    assign o_flush_e   = w_ctrl.flush_e;
    assign o_flush_w   = w_ctrl.flush_w;
    assign o_halted    = (r_state == HALT);
    assign o_err       = r_err;
    assign o_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire
